// File: rtl/motor_countdown_timer_pkg.sv
// Shared definitions for the motor-run countdown timer, the motor FSM and the display decoder.
// Holds the timer state encoding and the default width/ceiling of the remaining-time value.
package motor_timer_pkg;

  localparam int TIME_W_DEFAULT   = 5;
  localparam int MAX_TIME_DEFAULT = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/motor_countdown_timer.sv
// Registered countdown timer for the motor-run phase: load, tick-down, pause, cancel, retrigger, expiry pulse.
// Optional macro MOTOR_TIMER_AUTO_RELOAD_EN: expiry reloads the last saturated preset and keeps running.
module motor_countdown_timer
  import motor_timer_pkg::*;
#(
  parameter int TIME_W   = TIME_W_DEFAULT,
  parameter int MAX_TIME = MAX_TIME_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_tick,
  input  logic              i_start,
  input  logic [TIME_W-1:0] i_preset,
  input  logic              i_pause,
  input  logic              i_cancel,
  output logic [TIME_W-1:0] o_time,
  output logic              o_running,
  output logic              o_expired,
  output logic [1:0]        o_state
);

  localparam logic [TIME_W-1:0] MAX_T  = TIME_W'(MAX_TIME);
  localparam logic [TIME_W-1:0] ONE_T  = TIME_W'(1);
  localparam logic [TIME_W-1:0] ZERO_T = '0;

  state_t            state;
  state_t            state_nxt;
  logic [TIME_W-1:0] time_nxt;
  logic [TIME_W-1:0] preset_sat;
  logic              running_nxt;

  assign preset_sat = (i_preset > MAX_T) ? MAX_T : i_preset;
  assign o_state    = state;

`ifdef MOTOR_TIMER_AUTO_RELOAD_EN
  logic [TIME_W-1:0] period_q;
  logic [TIME_W-1:0] period_nxt;
`endif

  // Next-state and next-count decode; cancel beats start, start beats pause, pause beats tick.
  always_comb begin
    state_nxt = state;
    time_nxt  = o_time;
`ifdef MOTOR_TIMER_AUTO_RELOAD_EN
    period_nxt = period_q;
`endif
    if (i_cancel) begin
      state_nxt = ST_IDLE;
      time_nxt  = ZERO_T;
    end else if (i_start) begin
`ifdef MOTOR_TIMER_AUTO_RELOAD_EN
      period_nxt = preset_sat;
`endif
      time_nxt  = preset_sat;
      state_nxt = (preset_sat == ZERO_T) ? ST_DONE : ST_RUN;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_nxt = ST_IDLE;
        end
        ST_RUN: begin
          if (i_pause) begin
            state_nxt = ST_PAUSE;
          end else if (i_tick) begin
            if (o_time > ONE_T) begin
              time_nxt = o_time - ONE_T;
            end else begin
              time_nxt  = ZERO_T;
              state_nxt = ST_DONE;
            end
          end
        end
        ST_PAUSE: begin
          if (!i_pause) state_nxt = ST_RUN;
        end
        ST_DONE: begin
`ifdef MOTOR_TIMER_AUTO_RELOAD_EN
          if (period_q != ZERO_T) begin
            state_nxt = ST_RUN;
            time_nxt  = period_q;
          end else begin
            state_nxt = ST_IDLE;
          end
`else
          state_nxt = ST_IDLE;
`endif
        end
        default: begin
          state_nxt = ST_IDLE;
          time_nxt  = ZERO_T;
        end
      endcase
    end
  end

  // A looping period keeps the motor marked as running through its expiry cycle.
  always_comb begin
    running_nxt = (state_nxt == ST_RUN) || (state_nxt == ST_PAUSE);
`ifdef MOTOR_TIMER_AUTO_RELOAD_EN
    if ((state_nxt == ST_DONE) && (period_nxt != ZERO_T)) running_nxt = 1'b1;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state     <= ST_IDLE;
      o_time    <= ZERO_T;
      o_running <= 1'b0;
      o_expired <= 1'b0;
`ifdef MOTOR_TIMER_AUTO_RELOAD_EN
      period_q  <= ZERO_T;
`endif
    end else begin
      state     <= state_nxt;
      o_time    <= time_nxt;
      o_running <= running_nxt;
      o_expired <= (state_nxt == ST_DONE);
`ifdef MOTOR_TIMER_AUTO_RELOAD_EN
      period_q  <= period_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_motor_countdown_timer.sv
// Randomised scoreboard bench for motor_countdown_timer against a remaining-time/flag reference model.
// Honours MOTOR_TIMER_AUTO_RELOAD_EN in the model so either build can be checked.
module tb_motor_countdown_timer;

  localparam int TW   = 5;
  localparam int MAXT = 20;

`ifdef MOTOR_TIMER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          i_clk = 1'b1;
  logic          i_reset = 1'b0;
  logic          i_tick = 1'b0;
  logic          i_start = 1'b0;
  logic [TW-1:0] i_preset = '0;
  logic          i_pause = 1'b0;
  logic          i_cancel = 1'b0;
  logic [TW-1:0] o_time;
  logic          o_running;
  logic          o_expired;
  logic [1:0]    o_state;

  always #5 i_clk = ~i_clk;

  motor_countdown_timer #(.TIME_W(TW), .MAX_TIME(MAXT)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_tick   (i_tick),
    .i_start  (i_start),
    .i_preset (i_preset),
    .i_pause  (i_pause),
    .i_cancel (i_cancel),
    .o_time   (o_time),
    .o_running(o_running),
    .o_expired(o_expired),
    .o_state  (o_state)
  );

  typedef struct packed {
    logic [TW-1:0] tm;
    logic          run;
    logic          exp;
    logic [1:0]    st;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: remaining ticks plus "counting", "held" and "expiry pulse" flags.
  int m_rem = 0;
  int m_period = 0;
  bit m_active = 0;
  bit m_paused = 0;
  bit m_pulse = 0;

  task automatic modelStep(input bit rst_n, input bit start, input int preset,
                           input bit pause, input bit tick, input bit cancel);
    int p;
    if (!rst_n || cancel) begin
      m_rem = 0; m_active = 0; m_paused = 0; m_pulse = 0;
      if (!rst_n) m_period = 0;
    end else if (start) begin
      p = (preset > MAXT) ? MAXT : preset;
      m_period = p;
      m_rem    = p;
      m_paused = 0;
      m_active = (p != 0);
      m_pulse  = (p == 0);
    end else if (m_pulse) begin
      m_pulse = 0;
      if (AUTO && m_period > 0) begin
        m_rem = m_period; m_active = 1; m_paused = 0;
      end else begin
        m_active = 0;
      end
    end else if (m_active && !m_paused) begin
      if (pause) m_paused = 1;
      else if (tick) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin m_active = 0; m_pulse = 1; end
      end
    end else if (m_active && m_paused) begin
      if (!pause) m_paused = 0;
    end
  endtask

  function automatic exp_t modelOutputs();
    exp_t e;
    e.tm  = TW'(m_rem);
    e.exp = m_pulse;
    e.run = m_active || (AUTO && m_pulse && m_period > 0);
    e.st  = m_pulse ? 2'd3 : (m_active ? (m_paused ? 2'd2 : 2'd1) : 2'd0);
    return e;
  endfunction

  task automatic applyStimulus(input bit rst_n, input bit start, input int preset,
                               input bit pause, input bit tick, input bit cancel);
    @(negedge i_clk);
    i_reset  = rst_n;
    i_start  = start;
    i_preset = TW'(preset);
    i_pause  = pause;
    i_tick   = tick;
    i_cancel = cancel;
    modelStep(rst_n, start, preset, pause, tick, cancel);
    sb_q.push_back(modelOutputs());
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (o_time !== e.tm) begin
      errors++;
      $display("[TB] FAIL o_time: got %0d expected %0d at %0t", o_time, e.tm, $time);
    end
    checks++;
    if (o_running !== e.run) begin
      errors++;
      $display("[TB] FAIL o_running: got %0b expected %0b at %0t", o_running, e.run, $time);
    end
    checks++;
    if (o_expired !== e.exp) begin
      errors++;
      $display("[TB] FAIL o_expired: got %0b expected %0b at %0t", o_expired, e.exp, $time);
    end
    checks++;
    if (o_state !== e.st) begin
      errors++;
      $display("[TB] FAIL o_state: got %0d expected %0d at %0t", o_state, e.st, $time);
    end
  endtask

  // Monitor: every clock edge presents a fresh registered output word to compare.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL scoreboard: got no expected entry, required one at %0t", $time);
      end else begin
        checkOutput(sb_q.pop_front());
      end
    end
  end

  task automatic idle(input int n, input bit pause = 0);
    repeat (n) applyStimulus(1, 0, 0, pause, 0, 0);
  endtask

  task automatic ticks(input int n, input int gap, input bit pause = 0);
    repeat (n) begin
      idle(gap - 1, pause);
      applyStimulus(1, 0, 0, pause, 1, 0);
    end
  endtask

  initial begin
    bit pz;
    bit rst_n;
    repeat (3) applyStimulus(0, 1, int'($urandom_range(1, 31)), 0, 1, 0);
    idle(2);

    applyStimulus(1, 1, 3, 0, 0, 0);
    ticks(3, 10);
    idle(4);

    applyStimulus(1, 1, 5, 0, 0, 0);
    ticks(2, 3);
    applyStimulus(1, 0, 0, 1, 0, 0);
    ticks(4, 3, 1);
    applyStimulus(1, 0, 0, 0, 1, 0);
    ticks(3, 4);
    idle(3);

    applyStimulus(1, 1, 31, 0, 0, 0);
    ticks(2, 2);
    applyStimulus(1, 0, 0, 0, 0, 1);
    idle(2);
    applyStimulus(1, 1, 0, 0, 1, 0);
    idle(4);

    applyStimulus(1, 1, 4, 0, 0, 0);
    ticks(2, 3);
    applyStimulus(1, 0, 0, 0, 0, 1);
    idle(3);
    applyStimulus(1, 1, 3, 0, 0, 0);
    ticks(2, 2);
    applyStimulus(1, 1, 4, 0, 0, 0);
    idle(3);
    applyStimulus(1, 1, 7, 0, 0, 1);
    idle(3);

    applyStimulus(1, 1, 2, 0, 0, 0);
    ticks(6, 4);
    idle(5);
    applyStimulus(1, 0, 0, 0, 0, 1);
    idle(3);

    pz = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) pz = ~pz;
      rst_n = ($urandom_range(0, 149) != 0);
      applyStimulus(rst_n,
                    ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 31)),
                    pz,
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 39) == 0));
    end
    idle(2);

    @(posedge i_clk);
    #2;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/motor_countdown_timer.md
Name: motor_countdown_timer

Overview:
Parametrised, registered countdown timer that tracks the time remaining in a motor-run phase of the PWM controller FSM.
- Loads a preset and decrements once per external tick.
- Supports pause, cancel and retrigger.
- Emits a one-cycle expiry pulse.
- Drives the remaining-time value to the display path and the motor FSM.
- Replaces combinational remaining-time derivation with a clean, glitch-free registered count.

Parameters:
TIME_W, 5, width of preset and remaining-time value
MAX_TIME, 31, preset saturation ceiling; must be ≤ 2^TIME_W-1 and ≥ 1

Ports:
i_clk  input  1  system clock
i_reset  input  1  synchronous, active-low reset
i_tick  input  1  one-cycle enable per time unit (e.g. 1 Hz strobe)
i_start  input  1  one-cycle pulse: load i_preset and run
i_preset  input  TIME_W  requested duration in ticks
i_pause  input  1  level: hold count while high
i_cancel  input  1  one-cycle pulse: abort to IDLE, no expiry
o_time  output  TIME_W  registered remaining time
o_running  output  1  high in RUN or PAUSE
o_expired  output  1  one-cycle pulse when count reaches 0
o_state  output  2  current FSM state, encoding from package

Behaviour:
- Reset (i_reset==0 at rising edge): state IDLE; o_time=0, o_running=0, o_expired=0. Reset overrides all inputs.
- States: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- Input priority, highest first: reset > i_cancel > i_start > i_pause > i_tick.
- Preset load: o_time <= min(i_preset, MAX_TIME). Compare at TIME_W bits; no wrap.
- Start with a zero preset: o_time stays 0; go directly to DONE (o_expired pulses next cycle); no RUN cycle.
- IDLE:
  - i_start with preset≠0 → RUN, preset loaded.
  - i_tick and i_pause are ignored.
- RUN:
  - i_pause=1 → PAUSE; a tick in the same cycle is ignored.
  - i_tick with o_time>1 → o_time-1.
  - i_tick with o_time==1 → o_time=0, state DONE.
- PAUSE:
  - o_time is held; ticks are dropped, not accumulated.
  - i_pause=0 → RUN next cycle; a tick in that cycle is ignored.
- DONE:
  - Lasts exactly one cycle; o_expired=1 only in this state (registered, derived from the state).
  - Then → IDLE.
- Retrigger: i_start in RUN, PAUSE or DONE reloads the preset and enters RUN, or DONE if the preset is 0.
  - If this happens in DONE, the current pulse still completes.
- Cancel: i_cancel in any state → IDLE, o_time=0, no o_expired.
- Latency: every output is registered. Changes appear on the clock edge after the causing input is sampled.
- o_running = (state==RUN) | (state==PAUSE).
- o_time never underflows; decrement is only allowed when o_time≥1.

Optional Feature:
MOTOR_TIMER_AUTO_RELOAD_EN
- Defined:
  - The last loaded (saturated) preset is kept in an internal register.
  - DONE → RUN with o_time = stored preset. o_expired still pulses once per period.
  - If the stored preset is 0, go DONE → IDLE, so a zero period never loops.
  - i_cancel stops the loop.
  - o_running stays 1 across the DONE cycle.
- Undefined: DONE → IDLE always; no preset storage register exists.

Decomposition:
- Shared package motor_timer_pkg holds:
  - state localparams: ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE (2-bit);
  - default TIME_W and MAX_TIME constants, shared with the motor FSM and display decoder.
- No sub-module: the FSM and down-counter are one module.
- The i_tick source (clock prescaler) is a separate existing block instantiated by the parent, not inside this block.

Test Plan:
- Reset: hold i_reset=0 for 3 cycles with i_start=1 → o_time=0, o_state=IDLE, o_expired=0, o_running=0.
- Basic countdown: preset=3, start, then 3 ticks spaced 10 cycles apart.
  - o_time steps 3→2→1→0.
  - o_expired=1 exactly one cycle, one cycle after the third tick.
  - Then IDLE.
- Pause: preset=5, 2 ticks, raise i_pause, 4 ticks, drop i_pause, 3 ticks.
  - o_time=3 throughout the pause.
  - Expiry after the 3rd post-pause tick.
- Saturation and zero: preset=31 with MAX_TIME=20 → o_time=20. Preset=0 → immediate DONE, one o_expired, no RUN cycle.
- Cancel and retrigger:
  - Cancel at o_time=2 → IDLE, o_time=0, no expiry.
  - Start with preset=4 during RUN at o_time=1 → o_time=4, RUN, no expiry.
  - Cancel and start in the same cycle → IDLE.
- Auto-reload (macro defined): preset=2, 6 ticks → o_expired pulses 3 times, o_running stays 1. Cancel → IDLE.
